// File: rtl/lsr_stream_if.sv
// Sample/result bundle for lsr_stream: start/config, sample stream, fit results.
// master drives start, mode, shift and the sample stream; slave returns in_ready and results.
// Signal widths follow DATA_W (samples) and OUT_W (slope/intercept).
interface lsr_stream_if #(
    parameter int DATA_W = 16,
    parameter int OUT_W  = 32
);
    logic                     start;
    logic                     mode;
    logic [4:0]               shift;
    logic signed [DATA_W-1:0] x_in;
    logic signed [DATA_W-1:0] y_in;
    logic                     in_valid;
    logic                     in_last;
    logic                     in_ready;
    logic                     busy;
    logic signed [OUT_W-1:0]  slope;
    logic signed [OUT_W-1:0]  intercept;
    logic                     out_valid;
    logic                     err;

    modport master (
        output start, mode, shift, x_in, y_in, in_valid, in_last,
        input  in_ready, busy, slope, intercept, out_valid, err
    );

    modport slave (
        input  start, mode, shift, x_in, y_in, in_valid, in_last,
        output in_ready, busy, slope, intercept, out_valid, err
    );
endinterface

// File: rtl/lsr_stream.sv
// Streaming least-squares fit y = m*x + b; slope/intercept in signed fixed point (FRAC_W frac bits).
// Latency: out_valid pulses 2*OUT_W+4 cycles after the final (in_last or MAX_N-th) sample handshake.
// Backpressure: in_ready high only while collecting samples; one fit in flight, start ignored after ACCUM.
// Ports: clk, rst (async active-low), bus (lsr_stream_if.slave: start/mode/shift, x/y sample stream,
//        slope/intercept/out_valid/err/busy). Optional LSR_SUMS_EN adds sum_n/x/y/xy/xx outputs.
module lsr_stream #(
    parameter int DATA_W = 16,
    parameter int MAX_N  = 64,
    parameter int FRAC_W = 8,
    parameter int OUT_W  = 32
) (
    input  logic clk,
    input  logic rst,
    lsr_stream_if.slave bus
`ifdef LSR_SUMS_EN
    ,
    output logic [$clog2(MAX_N+1)-1:0]                  sum_n,
    output logic signed [2*DATA_W+$clog2(MAX_N)+1:0]    sum_x,
    output logic signed [2*DATA_W+$clog2(MAX_N)+1:0]    sum_y,
    output logic signed [2*DATA_W+$clog2(MAX_N)+1:0]    sum_xy,
    output logic signed [2*DATA_W+$clog2(MAX_N)+1:0]    sum_xx
`endif
);
    localparam int NW    = $clog2(MAX_N + 1);
    localparam int ACC_W = 2 * DATA_W + $clog2(MAX_N) + 2;
    localparam int PW    = 2 * ACC_W + 2;               // den / numm / numb
    localparam int DW    = PW + FRAC_W + OUT_W + 1;     // divider datapath, holds divisor<<OUT_W
    localparam int CW    = $clog2(OUT_W);

    typedef enum logic [2:0] {IDLE, ACCUM, PROD, DIV_M, ICPT, DIV_B, DONE} state_t;
    state_t state_q, state_d;

    logic                     mode_q;
    logic [4:0]               shift_q;
    logic [NW-1:0]            n_q;
    logic signed [ACC_W-1:0]  sx_q, sy_q, sxy_q, sxx_q;
    logic [CW-1:0]            cnt_q;
    logic signed [PW-1:0]     den_q, numm_q;
    logic [DW-1:0]            rem_q, dsh_q;
    logic [OUT_W-1:0]         quo_q;
    logic                     ovf_q, neg_q, deg_q;
    logic signed [OUT_W-1:0]  m_q, slope_q, icpt_q;
    logic                     vld_q, err_q;

    function automatic logic [DW-1:0] mag(input logic signed [PW-1:0] v);
        logic signed [PW-1:0] a;
        a = v[PW-1] ? -v : v;
        return {{(DW-PW){1'b0}}, a};
    endfunction

    // Quotient magnitude plus pre-detected overflow -> signed, saturated result.
    function automatic logic signed [OUT_W-1:0] sat(input logic [OUT_W-1:0] q,
                                                    input logic ovf, input logic neg);
        logic [OUT_W-1:0] lim;
        lim = {1'b1, {(OUT_W-1){1'b0}}};
        if (neg) return (ovf || q > lim) ? $signed(lim) : $signed(-q);
        return (ovf || q[OUT_W-1]) ? $signed(~lim) : $signed(q);
    endfunction

    logic hs, last_hs, q_bit;
    assign bus.in_ready = (state_q == ACCUM) && (n_q < NW'(MAX_N));
    assign hs      = bus.in_valid && bus.in_ready;
    assign last_hs = hs && !bus.start && (bus.in_last || n_q == NW'(MAX_N - 1));
    // Divisor is pre-shifted by OUT_W-1 and walks right, so OUT_W steps yield OUT_W quotient bits.
    assign q_bit   = rem_q >= dsh_q;

    logic signed [ACC_W-1:0] x_cur, y_cur, sx_nx, sy_nx, sxy_nx, sxx_nx;
    logic signed [PW-1:0]    sx_w, sy_w, n_w, den_nx, numm_nx, numb;
    logic signed [OUT_W-1:0] m_c, b_c;

    always_comb begin
        x_cur   = mode_q ? ACC_W'(bus.x_in) : $signed({{(ACC_W-NW){1'b0}}, n_q});
        y_cur   = ACC_W'(bus.y_in);
        sx_nx   = sx_q + x_cur;
        sy_nx   = sy_q + y_cur;
        sxy_nx  = sxy_q + x_cur * y_cur;
        sxx_nx  = sxx_q + x_cur * x_cur;
        sx_w    = PW'(sx_q);
        sy_w    = PW'(sy_q);
        n_w     = $signed({{(PW-NW){1'b0}}, n_q});
        den_nx  = den_q - sx_w * sx_w;
        numm_nx = numm_q - sx_w * sy_w;
        m_c     = deg_q ? '0 : sat(quo_q, ovf_q, neg_q);
        numb    = (sy_w <<< FRAC_W) - PW'(m_c) * sx_w;
        b_c     = (n_q < NW'(2)) ? '0 : sat(quo_q, ovf_q, neg_q);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = ACCUM;
            ACCUM:   if (last_hs) state_d = PROD;
            PROD:    if (cnt_q == CW'(1)) state_d = DIV_M;
            DIV_M:   if (cnt_q == CW'(OUT_W - 1)) state_d = ICPT;
            ICPT:    state_d = DIV_B;
            DIV_B:   if (cnt_q == CW'(OUT_W - 1)) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            mode_q  <= 1'b0;
            shift_q <= '0;
            n_q     <= '0;
            sx_q    <= '0;
            sy_q    <= '0;
            sxy_q   <= '0;
            sxx_q   <= '0;
            cnt_q   <= '0;
            den_q   <= '0;
            numm_q  <= '0;
            rem_q   <= '0;
            dsh_q   <= '0;
            quo_q   <= '0;
            ovf_q   <= 1'b0;
            neg_q   <= 1'b0;
            deg_q   <= 1'b0;
            m_q     <= '0;
            slope_q <= '0;
            icpt_q  <= '0;
            vld_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            vld_q   <= 1'b0;
            cnt_q   <= (state_d != state_q) ? '0 : cnt_q + CW'(1);
            case (state_q)
                IDLE, ACCUM: begin
                    if (bus.start) begin
                        mode_q  <= bus.mode;
                        shift_q <= bus.shift;
                        n_q     <= '0;
                        sx_q    <= '0;
                        sy_q    <= '0;
                        sxy_q   <= '0;
                        sxx_q   <= '0;
                        err_q   <= 1'b0;
                    end else if (hs) begin
                        n_q   <= n_q + NW'(1);
                        sx_q  <= sx_nx;
                        sy_q  <= sy_nx;
                        sxy_q <= sxy_nx;
                        sxx_q <= sxx_nx;
                    end
                end
                PROD: begin
                    if (cnt_q == '0) begin
                        den_q  <= n_w * PW'(sxx_q);
                        numm_q <= n_w * PW'(sxy_q);
                    end else begin
                        rem_q <= mag(numm_nx) << FRAC_W;
                        dsh_q <= mag(den_nx) << (OUT_W - 1);
                        ovf_q <= (mag(numm_nx) << FRAC_W) >= (mag(den_nx) << OUT_W);
                        neg_q <= numm_nx[PW-1] ^ den_nx[PW-1];
                        deg_q <= (den_nx == '0) || (n_q < NW'(2));
                    end
                end
                DIV_M, DIV_B: begin
                    if (q_bit) rem_q <= rem_q - dsh_q;
                    dsh_q <= dsh_q >> 1;
                    quo_q <= {quo_q[OUT_W-2:0], q_bit};
                end
                ICPT: begin
                    m_q   <= m_c;
                    rem_q <= mag(numb);
                    dsh_q <= DW'(n_q) << (OUT_W - 1);
                    ovf_q <= mag(numb) >= (DW'(n_q) << OUT_W);
                    neg_q <= numb[PW-1];
                end
                DONE: begin
                    slope_q <= m_q >>> shift_q;
                    icpt_q  <= b_c >>> shift_q;
                    vld_q   <= 1'b1;
                    err_q   <= deg_q;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy      = (state_q != IDLE);
    assign bus.slope     = slope_q;
    assign bus.intercept = icpt_q;
    assign bus.out_valid = vld_q;
    assign bus.err       = err_q;

`ifdef LSR_SUMS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sum_n  <= '0;
            sum_x  <= '0;
            sum_y  <= '0;
            sum_xy <= '0;
            sum_xx <= '0;
        end else if (bus.start && (state_q == IDLE || state_q == ACCUM)) begin
            sum_n  <= '0;
            sum_x  <= '0;
            sum_y  <= '0;
            sum_xy <= '0;
            sum_xx <= '0;
        end else if (state_q == ACCUM && state_d == PROD) begin
            sum_n  <= n_q + NW'(1);
            sum_x  <= sx_nx;
            sum_y  <= sy_nx;
            sum_xy <= sxy_nx;
            sum_xx <= sxx_nx;
        end
    end
`endif
endmodule

// File: tb/tb_lsr_stream.sv
// Scoreboard bench for lsr_stream: stimulus pushes expected fits, per-DUT monitors pop on out_valid.
// Two instances: MAX_N=64 (main cases) and MAX_N=4 (sample-count limit).
// Expected values are hand-computed from the least-squares formulas.
module tb_lsr_stream;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int hs0   = 0;
    int hs1   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic signed [31:0] s;
        logic signed [31:0] b;
        logic               e;
        int                 id;
    } exp_t;
    exp_t q0[$];
    exp_t q1[$];
    int   xs[$];
    int   ys[$];

    lsr_stream_if #(.DATA_W(16), .OUT_W(32)) b0 ();
    lsr_stream_if #(.DATA_W(16), .OUT_W(32)) b1 ();

`ifdef LSR_SUMS_EN
    logic [6:0]         s0_n;
    logic signed [39:0] s0_x, s0_y, s0_xy, s0_xx;
    logic [2:0]         s1_n;
    logic signed [35:0] s1_x, s1_y, s1_xy, s1_xx;
`endif

    lsr_stream #(.DATA_W(16), .MAX_N(64), .FRAC_W(8), .OUT_W(32)) u0 (
        .clk(clk), .rst(rst), .bus(b0)
`ifdef LSR_SUMS_EN
        , .sum_n(s0_n), .sum_x(s0_x), .sum_y(s0_y), .sum_xy(s0_xy), .sum_xx(s0_xx)
`endif
    );
    lsr_stream #(.DATA_W(16), .MAX_N(4), .FRAC_W(8), .OUT_W(32)) u1 (
        .clk(clk), .rst(rst), .bus(b1)
`ifdef LSR_SUMS_EN
        , .sum_n(s1_n), .sum_x(s1_x), .sum_y(s1_y), .sum_xy(s1_xy), .sum_xx(s1_xx)
`endif
    );

    task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitors: every out_valid must match the oldest expectation, at fixed latency.
    always @(negedge clk) begin : mon0
        exp_t e;
        if (b0.out_valid === 1'b1) begin
            if (q0.size() == 0) begin
                total++; bad++;
                $display("FAIL dut0_unexpected_out_valid: got 1 expected 0");
            end else begin
                e = q0.pop_front();
                chk($sformatf("fit%0d_slope", e.id), b0.slope, e.s);
                chk($sformatf("fit%0d_intercept", e.id), b0.intercept, e.b);
                chk($sformatf("fit%0d_err", e.id), b0.err, e.e);
                chk($sformatf("fit%0d_latency", e.id), cyc - hs0, 68);
            end
        end
    end

    always @(negedge clk) begin : mon1
        exp_t e;
        if (b1.out_valid === 1'b1) begin
            if (q1.size() == 0) begin
                total++; bad++;
                $display("FAIL dut1_unexpected_out_valid: got 1 expected 0");
            end else begin
                e = q1.pop_front();
                chk($sformatf("fit%0d_slope", e.id), b1.slope, e.s);
                chk($sformatf("fit%0d_intercept", e.id), b1.intercept, e.b);
                chk($sformatf("fit%0d_err", e.id), b1.err, e.e);
                chk($sformatf("fit%0d_latency", e.id), cyc - hs1, 68);
            end
        end
    end

    task automatic pulse_start(input logic m, input logic [4:0] sh);
        b0.start = 1'b1; b0.mode = m; b0.shift = sh;
        @(negedge clk);
        b0.start = 1'b0;
    endtask

    task automatic push(input int x, input int y, input logic last);
        int t = 0;
        b0.in_valid = 1'b1; b0.x_in = 16'(x); b0.y_in = 16'(y); b0.in_last = last;
        while (b0.in_ready !== 1'b1 && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (b0.in_ready !== 1'b1) begin
            total++; bad++;
            $display("FAIL push_timeout: in_ready got %b expected 1", b0.in_ready);
        end
        @(negedge clk);
        hs0 = cyc;
        b0.in_valid = 1'b0; b0.in_last = 1'b0;
    endtask

    task automatic run_fit(input int id, input logic m, input logic [4:0] sh,
                           input logic signed [31:0] es, input logic signed [31:0] eb,
                           input logic ee, input bit expect_out);
        exp_t e;
        e.s = es; e.b = eb; e.e = ee; e.id = id;
        if (expect_out) q0.push_back(e);
        pulse_start(m, sh);
        for (int i = 0; i < ys.size(); i++) push(xs[i], ys[i], i == ys.size() - 1);
    endtask

    task automatic wait_idle(input bit which);
        int t = 0;
        while ((which ? b1.busy : b0.busy) !== 1'b0 && t < 400) begin
            @(negedge clk);
            t++;
        end
        if ((which ? b1.busy : b0.busy) !== 1'b0) begin
            total++; bad++;
            $display("FAIL busy_timeout dut%0d: busy got 1 expected 0", which);
        end
        @(negedge clk);
    endtask

    initial begin
        int   nhs;
        exp_t e1;
        rst = 1'b1;
        b0.start = 0; b0.mode = 0; b0.shift = 0; b0.x_in = 0; b0.y_in = 0; b0.in_valid = 0; b0.in_last = 0;
        b1.start = 0; b1.mode = 0; b1.shift = 0; b1.x_in = 0; b1.y_in = 0; b1.in_valid = 0; b1.in_last = 0;
        #2 rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", b0.in_ready, 0);
        chk("rst_busy", b0.busy, 0);
        chk("rst_out_valid", b0.out_valid, 0);
        chk("rst_err", b0.err, 0);
        chk("rst_slope", b0.slope, 0);
        chk("rst_intercept", b0.intercept, 0);
        rst = 1'b1;
        @(negedge clk);
        chk("idle_in_ready", b0.in_ready, 0);

        // y = 2x + 3 over x = 0..4
        xs = '{0, 0, 0, 0, 0}; ys = '{3, 5, 7, 9, 11};
        run_fit(1, 1'b0, 5'd0, 512, 768, 1'b0, 1'b1);
        wait_idle(1'b0);

        // y = -2x + 12 with explicit x
        xs = '{1, 2, 3, 4}; ys = '{10, 8, 6, 4};
        run_fit(2, 1'b1, 5'd0, -512, 3072, 1'b0, 1'b1);
        wait_idle(1'b0);

        // Reset while the slope divide is running
        xs = '{0, 0, 0, 0, 0}; ys = '{3, 5, 7, 9, 11};
        run_fit(3, 1'b0, 5'd0, 0, 0, 1'b0, 1'b0);
        repeat (10) @(negedge clk);
        chk("pre_reset_busy", b0.busy, 1);
        #1 rst = 1'b0;
        #1;
        chk("midreset_slope", b0.slope, 0);
        chk("midreset_intercept", b0.intercept, 0);
        chk("midreset_busy", b0.busy, 0);
        chk("midreset_out_valid", b0.out_valid, 0);
        chk("midreset_in_ready", b0.in_ready, 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (80) @(negedge clk);

        run_fit(4, 1'b0, 5'd0, 512, 768, 1'b0, 1'b1);
        wait_idle(1'b0);

        run_fit(5, 1'b0, 5'd4, 32, 48, 1'b0, 1'b1);
        wait_idle(1'b0);

        // Restart after two junk samples
        pulse_start(1'b0, 5'd0);
        push(0, 100, 1'b0);
        push(0, -50, 1'b0);
        run_fit(6, 1'b0, 5'd0, 512, 768, 1'b0, 1'b1);
        wait_idle(1'b0);

        // All x equal: degenerate slope, intercept = mean(y)
        xs = '{5, 5, 5}; ys = '{1, 2, 3};
        run_fit(7, 1'b1, 5'd0, 0, 512, 1'b1, 1'b1);
        wait_idle(1'b0);

        // Single sample
        xs = '{5}; ys = '{7};
        run_fit(8, 1'b1, 5'd0, 0, 0, 1'b1, 1'b1);
        wait_idle(1'b0);

        // MAX_N=4 instance: valid held, no in_last
        b1.start = 1'b1; b1.mode = 1'b0; b1.shift = 5'd0;
        @(negedge clk);
        b1.start = 1'b0;
        e1.s = 0; e1.b = 512; e1.e = 1'b0; e1.id = 9;
        q1.push_back(e1);
        b1.in_valid = 1'b1; b1.x_in = 16'sd0; b1.y_in = 16'sd2; b1.in_last = 1'b0;
        nhs = 0;
        for (int i = 0; i < 10; i++) begin
            if (b1.in_ready === 1'b1) begin
                nhs++;
                hs1 = cyc + 1;
            end
            @(negedge clk);
        end
        chk("maxn_handshakes", nhs, 4);
        chk("maxn_in_ready_low", b1.in_ready, 0);
        b1.in_valid = 1'b0;
        wait_idle(1'b1);

        repeat (2) @(negedge clk);
        chk("q0_drained", q0.size(), 0);
        chk("q1_drained", q1.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/lsr_stream.md
Name: lsr_stream

Overview:
- Streaming, parametrised least-squares linear-regression engine: fits y = m·x + b over a variable-length sample set and returns fixed-point slope and intercept.
- Successor to the fixed-size array regression block. It accepts samples over a valid/ready handshake, supports run-time length up to MAX_N, and takes x either as the implicit sample index or from an explicit x stream.
- Sits between the sample front-end and the fit consumer; one fit is in flight at a time.

Parameters:
DATA_W, 16, signed width of x_in and y_in
MAX_N, 64, maximum samples per fit (>=2)
FRAC_W, 8, fractional bits of slope/intercept results
OUT_W, 32, signed width of slope and intercept outputs

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset
start  input  1  one-cycle pulse; clears accumulators and opens a new sample set
mode  input  1  sampled on start: 0 = x is the sample index 0..n-1, 1 = x from x_in
shift  input  5  arithmetic right shift applied to both results; sampled on start
x_in  input  DATA_W  signed x sample; ignored when mode=0
y_in  input  DATA_W  signed y sample
in_valid  input  1  sample present
in_last  input  1  qualifies the final sample of the set
in_ready  output  1  block accepts a sample
busy  output  1  high from start until out_valid
slope  output  OUT_W  signed m, FRAC_W fractional bits
intercept  output  OUT_W  signed b, FRAC_W fractional bits
out_valid  output  1  one-cycle pulse; results valid
err  output  1  degenerate fit flag; valid with out_valid and held until next start

Behaviour:
- Reset (rst=0, async): state IDLE; in_ready, busy, out_valid, err = 0; slope, intercept, and all accumulators = 0. Reset mid-fit abandons the fit and produces no out_valid.
- FSM states: IDLE -> ACCUM -> PROD -> DIV_M -> ICPT -> DIV_B -> DONE -> IDLE.
- IDLE: start -> ACCUM. Clears n, Σx, Σy, Σxy, Σxx and err, latches mode and shift, sets busy=1.
- ACCUM: in_ready=1 while n<MAX_N. Each handshake (in_valid & in_ready) adds x, y, x·y, x·x and increments n.
  - mode=0: x = n before the increment.
  - Leave ACCUM on a handshake with in_last=1, or when n reaches MAX_N (in_ready drops the cycle after the MAX_N-th handshake).
  - start during ACCUM restarts the set.
  - start in any later state is ignored.
- Accumulators are sized exactly (no wrap): ACC_W = 2·DATA_W + clog2(MAX_N) + 2. Product terms are wide enough that nothing is truncated.
- PROD (2 cycles):
  - den = n·Σxx − Σx²
  - numm = n·Σxy − Σx·Σy
- DIV_M (OUT_W cycles): sequential restoring divide of |numm<<FRAC_W| by |den|; sign applied afterwards; truncates toward zero. If the magnitude exceeds OUT_W signed range, saturate to max/min.
- ICPT (1 cycle): numb = (Σy<<FRAC_W) − m·Σx, where m is the unshifted quotient.
- DIV_B (OUT_W cycles): b = numb / n, with the same rounding and saturation rules.
- DONE (1 cycle): slope = m >>> shift, intercept = b >>> shift; out_valid=1, busy=0. Outputs hold until the next start.
- Latency: out_valid asserts exactly 2·OUT_W+4 cycles after the final-sample handshake (or after the MAX_N-th handshake). Error paths keep the same timing.
- Degenerate cases:
  - n=0 or n=1: err=1, slope=0, intercept=0.
  - den=0 with n>=2 (all x equal, mode 1 only): err=1, slope=0, intercept = (Σy<<FRAC_W)/n >>> shift.
- A simultaneous in_valid and start in IDLE: start takes effect; the sample is not accepted (in_ready=0 in IDLE).

Optional Feature:
- Macro: LSR_SUMS_EN.
- Defined: extra outputs sum_n (clog2(MAX_N+1)), sum_x, sum_y, sum_xy, sum_xx (ACC_W each), registered when leaving ACCUM, held until the next start, and reset to 0.
- Undefined: these ports do not exist and no sum registers are exposed; core behaviour is identical.

Test Plan:
- Defaults. mode=0, shift=0, y = 3,5,7,9,11 with in_last on 11 -> slope=512, intercept=768, err=0. out_valid exactly 68 cycles after the last handshake.
- mode=1, x = 1,2,3,4, y = 10,8,6,4 -> slope=-512, intercept=3072, err=0.
- Repeat the first case with shift=4 -> slope=32, intercept=48.
- mode=1, x = 5,5,5, y = 1,2,3 -> err=1, slope=0, intercept=512. Then a single sample with in_last -> err=1, slope=0, intercept=0.
- MAX_N=4 build, mode=0, y=2 held valid, no in_last -> exactly 4 handshakes, in_ready low afterwards, slope=0, intercept=512.
- Pull rst low during DIV_M -> all outputs 0 immediately and no out_valid. A fresh start then fits correctly.
- Pulse start mid-ACCUM after 2 samples, then send the first-case set -> first-case results.
